apb_bus_arbiter: RTL and testbench

Round-robin APB master-side arbiter and sequencer that shares one APB bus between `NREQ` local requesters. It accepts level requests carrying address, write data and direction, and grants one requester at a time. It drives the APB SETUP/ACCESS phases (`pselx`, `penable`, `paddr`, `pwrite`, `pwdata`) and returns read data plus a one-cycle completion pulse to the owner. It sits between the bus-master clients and the APB slave, replacing per-client standalone APB FSMs.

---
 rtl/apb_bus_arbiter_pkg.sv | 14 +
 rtl/apb_bus_arbiter_if.sv | 27 ++
 rtl/apb_bus_arbiter_rr_arbiter.sv | 40 ++++
 rtl/apb_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_apb_bus_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_bus_arbiter_pkg.sv
// Shared constants for the APB bus arbiter: FSM state encoding and default widths.
package apb_arb_pkg;

    localparam int unsigned DefAw      = 8;
    localparam int unsigned DefDw      = 8;
    localparam int unsigned DefTimeout = 15;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StSetup  = 2'd1;
    localparam state_t StAccess = 2'd2;

endpackage

// File: rtl/apb_bus_arbiter_if.sv
// APB bus bundle between the arbiter (master side) and a single APB slave.
interface apb_bus_arbiter_if
    import apb_arb_pkg::*;
#(
    parameter int unsigned AW = DefAw,
    parameter int unsigned DW = DefDw
) ();

    logic          pselx;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;

    modport master (
        output pselx, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );

endinterface

// File: rtl/apb_bus_arbiter_rr_arbiter.sv
// Combinational circular priority search: first unmasked request at or after ptr wins.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    logic [N-1:0] eff;
    logic [PW:0]  sum;
    logic [PW-1:0] idx;
    logic         found;

    always_comb begin
        eff   = req & ~mask;
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // ptr < N and i < N, so a single subtraction wraps the sum
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && eff[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |eff;

endmodule

// File: rtl/apb_bus_arbiter.sv
// Round-robin APB master-side arbiter/sequencer for NREQ requesters.
// Optional ACCESS timeout abort is built when APB_TIMEOUT_EN is defined.
module apb_bus_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = DefAw,
    parameter int unsigned DW      = DefDw,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     wr,
    input  logic [NREQ*AW-1:0]  addr,
    input  logic [NREQ*DW-1:0]  wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [NREQ-1:0]     err,
    output logic [DW-1:0]       rdata,
    apb_bus_arbiter_if.master   apb
);

    localparam int unsigned PW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic [NREQ-1:0] win, arb_mask;
    logic [PW-1:0]   arb_ptr, owner_idx, ptr_inc;
    logic            any, timeout_hit;
    logic            sel_wr;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    always_comb begin
        owner_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt_q[k]) owner_idx = PW'(k);
        end
        ptr_inc = (owner_idx == PW'(NREQ - 1)) ? '0 : owner_idx + PW'(1);
    end

    // Owner is masked both while completing and during its done cycle, so a
    // client that has not yet reacted to done is not immediately re-granted.
    assign arb_mask = done_q | ((state_q == StAccess) ? gnt_q : '0);
    assign arb_ptr  = (state_q == StAccess) ? ptr_inc : ptr_q;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .req  (req),
        .mask (arb_mask),
        .ptr  (arb_ptr),
        .gnt  (win),
        .any  (any)
    );

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (win[k]) begin
                sel_wr    = wr[k];
                sel_addr  = addr[k*AW +: AW];
                sel_wdata = wdata[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = '0;
        case (state_q)
            StIdle: begin
                if (any) begin
                    state_d = StSetup;
                    gnt_d   = win;
                    wr_d    = sel_wr;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                if (apb.pready || timeout_hit) begin
                    done_d = gnt_q;
                    ptr_d  = ptr_inc;
                    if (apb.pready && !wr_q) rdata_d = apb.prdata;
                    if (any) begin
                        state_d = StSetup;
                        gnt_d   = win;
                        wr_d    = sel_wr;
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            done_q  <= '0;
            ptr_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    logic [7:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] err_q, err_d;

    // Hit fires on the wait cycle whose increment would reach TIMEOUT
    assign timeout_hit = (state_q == StAccess) && !apb.pready && (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StSetup) begin
            cnt_d = '0;
        end else if (state_q == StAccess && !apb.pready) begin
            cnt_d = cnt_q + 8'd1;
        end
        err_d = timeout_hit ? gnt_q : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = '0;
`endif

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign apb.pselx   = (state_q != StIdle);
    assign apb.penable = (state_q == StAccess);
    assign apb.pwrite  = wr_q;
    assign apb.paddr   = addr_q;
    assign apb.pwdata  = wdata_q;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Directed self-checking bench for apb_bus_arbiter (timeout scenario when APB_TIMEOUT_EN).
module tb_apb_bus_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ-1:0]     wr = '0;
    logic [NREQ*AW-1:0]  addr = '0;
    logic [NREQ*DW-1:0]  wdata = '0;
    logic [NREQ-1:0]     gnt, done, err;
    logic [DW-1:0]       rdata;

    int n_checks = 0;
    int n_fail   = 0;

    apb_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    apb_bus_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .gnt   (gnt),
        .done  (done),
        .err   (err),
        .rdata (rdata),
        .apb   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req = '0;
        bus.pready = 1'b0;
        bus.prdata = '0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.pready = 1'b0;
        bus.prdata = '0;
        step();
        n_checks++;
        if ({gnt, done, err, rdata, bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b done=%b err=%b rdata=%h psel=%b pen=%b pwr=%b paddr=%h pwdata=%h required all 0",
                     gnt, done, err, rdata, bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({gnt, bus.pselx, bus.penable} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got gnt=%b psel=%b pen=%b required 0", gnt, bus.pselx, bus.penable);
        end
    endtask

    task automatic test_single_write();
        apply_reset();
        bus.pready = 1'b1;
        wr = 4'b0100;
        addr[2*AW +: AW] = 8'h3C;
        wdata[2*DW +: DW] = 8'hA5;
        req = 4'b0100;
        for (int c = 1; c <= 2; c++) begin
            step();
            n_checks++;
            if (bus.paddr !== 8'h3C || bus.pwdata !== 8'hA5 || bus.pwrite !== 1'b1) begin
                n_fail++;
                $display("FAIL wr_bus_c%0d: got paddr=%h pwdata=%h pwrite=%b required 3c a5 1",
                         c, bus.paddr, bus.pwdata, bus.pwrite);
            end
            n_checks++;
            if ({bus.pselx, bus.penable} !== ((c == 1) ? 2'b10 : 2'b11) || gnt !== 4'b0100) begin
                n_fail++;
                $display("FAIL wr_ctrl_c%0d: got psel_pen=%b gnt=%b required %b 0100",
                         c, {bus.pselx, bus.penable}, gnt, (c == 1) ? 2'b10 : 2'b11);
            end
        end
        step();
        n_checks++;
        if (done !== 4'b0100 || err !== 4'b0000 || gnt !== 4'b0000 || bus.pselx !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done: got done=%b err=%b gnt=%b psel=%b required 0100 0000 0000 0",
                     done, err, gnt, bus.pselx);
        end
        req = '0;
        step();
        n_checks++;
        if (done !== 4'b0000 || bus.pselx !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_after: got done=%b psel=%b required 0000 0", done, bus.pselx);
        end
    endtask

    task automatic test_read_wait();
        apply_reset();
        wr = 4'b0000;
        addr[0 +: AW] = 8'h12;
        bus.prdata = 8'hFF;
        req = 4'b0001;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 4) begin
                bus.pready = 1'b1;
                bus.prdata = 8'h5A;
            end
            n_checks++;
            if (bus.paddr !== 8'h12 || bus.pselx !== 1'b1 || bus.penable !== (c != 1) || done !== 4'b0000) begin
                n_fail++;
                $display("FAIL rd_c%0d: got paddr=%h psel=%b pen=%b done=%b required 12 1 %b 0000",
                         c, bus.paddr, bus.pselx, bus.penable, done, c != 1);
            end
        end
        step();
        n_checks++;
        if (done !== 4'b0001 || rdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL rd_done: got done=%b rdata=%h required 0001 5a", done, rdata);
        end
        req = '0;
        bus.prdata = 8'h00;
        step();
        n_checks++;
        if (rdata !== 8'h5A || done !== 4'b0000) begin
            n_fail++;
            $display("FAIL rd_hold: got rdata=%h done=%b required 5a 0000", rdata, done);
        end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] exp_gnt, exp_done;
        int own;
        apply_reset();
        bus.pready = 1'b1;
        wr = 4'b1111;
        for (int k = 0; k < 4; k++) addr[k*AW +: AW] = 8'(8'h10 + k);
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            own = t % 4;
            exp_gnt = 4'b0001 << own;
            exp_done = (t == 0) ? 4'b0000 : (4'b0001 << ((own + 3) % 4));
            step();
            n_checks++;
            if (gnt !== exp_gnt || {bus.pselx, bus.penable} !== 2'b10 || done !== exp_done
                || bus.paddr !== 8'(8'h10 + own)) begin
                n_fail++;
                $display("FAIL fair_setup_t%0d: got gnt=%b psel_pen=%b done=%b paddr=%h required %b 10 %b %h",
                         t, gnt, {bus.pselx, bus.penable}, done, bus.paddr, exp_gnt, exp_done, 8'(8'h10 + own));
            end
            step();
            if (t == 4) req = '0;
            n_checks++;
            if (gnt !== exp_gnt || {bus.pselx, bus.penable} !== 2'b11) begin
                n_fail++;
                $display("FAIL fair_access_t%0d: got gnt=%b psel_pen=%b required %b 11",
                         t, gnt, {bus.pselx, bus.penable}, exp_gnt);
            end
        end
        step();
        n_checks++;
        if (done !== 4'b0001 || bus.pselx !== 1'b0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL fair_end: got done=%b psel=%b gnt=%b required 0001 0 0000", done, bus.pselx, gnt);
        end
    endtask

    task automatic test_owner_mask();
        int n_done;
        int n_psel;
        apply_reset();
        bus.pready = 1'b1;
        wr = 4'b0000;
        req = 4'b0010;
        n_done = 0;
        n_psel = 0;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (done[1]) n_done++;
            if (c >= 3 && bus.pselx) n_psel++;
            if (c == 3) req = '0;
        end
        n_checks++;
        if (n_done != 1 || n_psel != 0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL owner_mask: got done_pulses=%0d busy_after=%0d gnt=%b required 1 0 0000",
                     n_done, n_psel, gnt);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.pready = 1'b1;
        wr = 4'b1111;
        req = 4'b0010;
        step();
        step();
        step();
        req = 4'b1000;
        bus.pready = 1'b0;
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.pselx !== 1'b0 || bus.penable !== 1'b0 || gnt !== 4'b0000 || done !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_async: got psel=%b pen=%b gnt=%b done=%b required 0 0 0000 0000",
                     bus.pselx, bus.penable, gnt, done);
        end
        req = '0;
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (bus.pselx !== 1'b0 || gnt !== 4'b0000 || done !== 4'b0000 || err !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_idle: got psel=%b gnt=%b done=%b err=%b required 0 0000 0000 0000",
                     bus.pselx, gnt, done, err);
        end
        bus.pready = 1'b1;
        req = 4'b1111;
        step();
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_prio: got gnt=%b required 0001", gnt);
        end
        req = '0;
        step();
        step();
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        int early;
        apply_reset();
        wr = 4'b0000;
        req = 4'b0100;
        early = 0;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (done !== 4'b0000 || err !== 4'b0000) early++;
        end
        n_checks++;
        if (early != 0 || bus.penable !== 1'b1) begin
            n_fail++;
            $display("FAIL to_wait: got early_pulses=%0d pen=%b required 0 1", early, bus.penable);
        end
        step();
        n_checks++;
        if (done !== 4'b0100 || err !== 4'b0100 || rdata !== 8'h00 || bus.pselx !== 1'b0) begin
            n_fail++;
            $display("FAIL to_abort: got done=%b err=%b rdata=%h psel=%b required 0100 0100 00 0",
                     done, err, rdata, bus.pselx);
        end
        req = '0;
        step();
        n_checks++;
        if (done !== 4'b0000 || err !== 4'b0000 || bus.pselx !== 1'b0) begin
            n_fail++;
            $display("FAIL to_idle: got done=%b err=%b psel=%b required 0000 0000 0", done, err, bus.pselx);
        end
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        apply_reset();
        wr = 4'b0000;
        req = 4'b0100;
        bad = 0;
        step();
        for (int c = 2; c <= 21; c++) begin
            step();
            if (bus.penable !== 1'b1 || done !== 4'b0000 || err !== 4'b0000) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL nto_wait: got bad_cycles=%0d required 0", bad);
        end
        bus.pready = 1'b1;
        bus.prdata = 8'h3C;
        step();
        n_checks++;
        if (done !== 4'b0100 || err !== 4'b0000 || rdata !== 8'h3C) begin
            n_fail++;
            $display("FAIL nto_done: got done=%b err=%b rdata=%h required 0100 0000 3c", done, err, rdata);
        end
        req = '0;
        step();
    endtask
`endif

    initial begin
        bus.pready = 1'b0;
        bus.prdata = '0;
        test_reset();
        test_single_write();
        test_read_wait();
        test_fairness();
        test_owner_mask();
        test_reset_mid();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
